// File: rtl/programmable_clock_divider.sv
// rtl/programmable_clock_divider.sv - programmable 50% duty clock divider with run/stop and boundary-aligned divisor reload
module programmable_clock_divider #(
    parameter int CNT_WIDTH = 8,
    parameter int RESET_DIV = 0
) (
    input  logic                 MCLK_IN,
    input  logic                 RST_N_IN,
    input  logic                 RUN_IN,
    input  logic [CNT_WIDTH-1:0] DIV_IN,
    input  logic                 DIV_LOAD_IN,
    output logic                 CPUCLK_OUT,
    output logic                 RISE_OUT,
    output logic                 FALL_OUT,
    output logic [CNT_WIDTH-1:0] DIV_CUR_OUT,
    output logic                 PEND_OUT
);

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        HIGH    = 2'd1,
        LOW     = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [CNT_WIDTH-1:0] count, count_nx;
    logic [CNT_WIDTH-1:0] div_cur, div_cur_nx;
    logic [CNT_WIDTH-1:0] div_pend, div_pend_nx;
    logic                 pend, pend_nx;
    logic                 cpuclk_nx, rise_nx, fall_nx;
    logic                 phase_end;

    // Equality compare only, so a divisor of all ones never needs the counter to wrap.
    assign phase_end = (count == div_cur);

    always_ff @(posedge MCLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            state      <= STOPPED;
            count      <= '0;
            div_cur    <= CNT_WIDTH'(RESET_DIV);
            div_pend   <= '0;
            pend       <= 1'b0;
            CPUCLK_OUT <= 1'b0;
            RISE_OUT   <= 1'b0;
            FALL_OUT   <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            div_cur    <= div_cur_nx;
            div_pend   <= div_pend_nx;
            pend       <= pend_nx;
            CPUCLK_OUT <= cpuclk_nx;
            RISE_OUT   <= rise_nx;
            FALL_OUT   <= fall_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        count_nx    = count;
        div_cur_nx  = div_cur;
        div_pend_nx = div_pend;
        pend_nx     = pend;
        cpuclk_nx   = CPUCLK_OUT;
        rise_nx     = 1'b0;
        fall_nx     = 1'b0;
        case (state)
            STOPPED: begin
                cpuclk_nx = 1'b0;
                if (DIV_LOAD_IN) begin
                    div_cur_nx = DIV_IN;
                    pend_nx    = 1'b0;
                end
                if (RUN_IN) begin
                    state_nx  = HIGH;
                    cpuclk_nx = 1'b1;
                    rise_nx   = 1'b1;
                    count_nx  = '0;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    state_nx  = LOW;
                    cpuclk_nx = 1'b0;
                    fall_nx   = 1'b1;
                    count_nx  = '0;
                end else begin
                    count_nx = count + 1'b1;
                end
                if (DIV_LOAD_IN) begin
                    div_pend_nx = DIV_IN;
                    pend_nx     = 1'b1;
                end
            end
            LOW: begin
                if (phase_end) begin
                    // Period boundary: a coincident load beats the pending value.
                    count_nx = '0;
                    if (DIV_LOAD_IN) begin
                        div_cur_nx = DIV_IN;
                        pend_nx    = 1'b0;
                    end else if (pend) begin
                        div_cur_nx = div_pend;
                        pend_nx    = 1'b0;
                    end
                    if (RUN_IN) begin
                        state_nx  = HIGH;
                        cpuclk_nx = 1'b1;
                        rise_nx   = 1'b1;
                    end else begin
                        state_nx  = STOPPED;
                        cpuclk_nx = 1'b0;
                    end
                end else begin
                    count_nx = count + 1'b1;
                    if (DIV_LOAD_IN) begin
                        div_pend_nx = DIV_IN;
                        pend_nx     = 1'b1;
                    end
                end
            end
            default: begin
                state_nx  = STOPPED;
                cpuclk_nx = 1'b0;
                count_nx  = '0;
            end
        endcase
    end

    assign DIV_CUR_OUT = div_cur;
    assign PEND_OUT    = pend;

endmodule

// File: tb/tb_programmable_clock_divider.sv
// tb/tb_programmable_clock_divider.sv - scoreboard bench for programmable_clock_divider
module tb_programmable_clock_divider;

    localparam int W         = 8;
    localparam int RESET_DIV = 0;

    logic         mclk = 1'b0;
    logic         rst_n = 1'b0;
    logic         run = 1'b0;
    logic [W-1:0] div = '0;
    logic         div_load = 1'b0;
    logic         cpuclk, rise, fall, pend;
    logic [W-1:0] div_cur;

    programmable_clock_divider #(.CNT_WIDTH(W), .RESET_DIV(RESET_DIV)) dut (
        .MCLK_IN    (mclk),
        .RST_N_IN   (rst_n),
        .RUN_IN     (run),
        .DIV_IN     (div),
        .DIV_LOAD_IN(div_load),
        .CPUCLK_OUT (cpuclk),
        .RISE_OUT   (rise),
        .FALL_OUT   (fall),
        .DIV_CUR_OUT(div_cur),
        .PEND_OUT   (pend)
    );

    always #5 mclk = ~mclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W+3:0] q[$];

    // Reference model: edges remaining in the current half period, counted down.
    bit           m_running, m_high, m_clk, m_rise, m_fall, m_pend;
    int           m_left;
    logic [W-1:0] m_cur, m_pdiv;

    task automatic model_reset();
        m_running = 0; m_high = 0; m_clk = 0; m_rise = 0; m_fall = 0;
        m_pend = 0; m_left = 0; m_cur = W'(RESET_DIV); m_pdiv = '0;
    endtask

    task automatic model_step(input bit r, input bit l, input logic [W-1:0] d);
        m_rise = 0;
        m_fall = 0;
        if (!m_running) begin
            if (l) m_cur = d;
            if (r) begin
                m_running = 1; m_high = 1; m_left = int'(m_cur) + 1;
                m_clk = 1; m_rise = 1;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left > 0) begin
                if (l) begin m_pend = 1; m_pdiv = d; end
            end else if (m_high) begin
                if (l) begin m_pend = 1; m_pdiv = d; end
                m_high = 0; m_clk = 0; m_fall = 1; m_left = int'(m_cur) + 1;
            end else begin
                if (l) begin m_cur = d; m_pend = 0; end
                else if (m_pend) begin m_cur = m_pdiv; m_pend = 0; end
                if (r) begin
                    m_high = 1; m_clk = 1; m_rise = 1; m_left = int'(m_cur) + 1;
                end else begin
                    m_running = 0; m_clk = 0;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit l, input logic [W-1:0] d);
        @(negedge mclk);
        #1;
        run = r; div_load = l; div = d;
        model_step(r, l, d);
        q.push_back({m_clk, m_rise, m_fall, m_cur, m_pend});
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(r, 0, '0);
    endtask

    always @(negedge mclk) begin
        logic [W+3:0] exp_v, got_v;
        cyc++;
        if (rst_n && q.size() > 0) begin
            exp_v = q.pop_front();
            got_v = {cpuclk, rise, fall, div_cur, pend};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL cycle_check cyc=%0d got clk/rise/fall/div/pend=%b/%b/%b/%0d/%b expected %b/%b/%b/%0d/%b",
                         cyc, got_v[W+3], got_v[W+2], got_v[W+1], got_v[W:1], got_v[0],
                         exp_v[W+3], exp_v[W+2], exp_v[W+1], exp_v[W:1], exp_v[0]);
            end
        end
    end

    task automatic check_reset_state(input string name);
        total++;
        if ({cpuclk, rise, fall, div_cur, pend} !== {3'b000, W'(RESET_DIV), 1'b0}) begin
            bad++;
            $display("FAIL %s got clk/rise/fall/div/pend=%b/%b/%b/%0d/%b expected 0/0/0/%0d/0",
                     name, cpuclk, rise, fall, div_cur, pend, RESET_DIV);
        end
    endtask

    // Steps with RUN_IN=1 until the model is at the given point of a high phase.
    task automatic run_until_high_left(input int left, input string name);
        bit found = 0;
        for (int i = 0; i < 1200 && !found; i++) begin
            step(1, 0, '0);
            if (m_high && m_left == left) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s_wait got no_match expected high phase with %0d edges left", name, left);
        end
    endtask

    initial begin
        model_reset();
        #12;
        check_reset_state("reset_state");
        @(negedge mclk); #1 rst_n = 1'b1;

        // Default divisor: divide by two right after reset.
        idle(10, 1);
        idle(6, 0);

        // D=19 loaded while stopped: 20 high, 20 low.
        step(0, 1, W'(19));
        idle(85, 1);
        idle(45, 0);

        // D=3 running, reload 1 mid-high.
        step(0, 1, W'(3));
        idle(3, 1);
        run_until_high_left(2, "reload_mid_high");
        step(1, 1, W'(1));
        idle(20, 1);

        // D=2, drop RUN one cycle after a rise, then restart.
        step(1, 1, W'(2));
        run_until_high_left(3, "stop_after_rise");
        idle(12, 0);
        idle(6, 1);

        // Run glitch inside a period has no effect.
        step(1, 0, '0);
        step(0, 0, '0);
        step(1, 0, '0);
        idle(10, 1);
        idle(12, 0);

        // Full-scale divisor: no counter wrap.
        step(0, 1, W'(255));
        idle(520, 1);
        step(1, 1, W'(4));
        idle(520, 1);

        // Asynchronous reset mid-high with D=5.
        idle(12, 0);
        step(0, 1, W'(5));
        idle(3, 1);
        @(posedge mclk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset_mid_high");
        q.delete();
        model_reset();
        run = 1'b0; div_load = 1'b0;
        @(negedge mclk); #1 rst_n = 1'b1;

        // Load coincident with start applies to the first period.
        step(1, 1, W'(4));
        idle(14, 1);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            bit r, l;
            logic [W-1:0] d;
            r = ($urandom_range(0, 99) < 93);
            l = ($urandom_range(0, 29) == 0);
            d = ($urandom_range(0, 9) == 0) ? W'(255) : W'($urandom_range(0, 6));
            step(r, l, d);
        end

        @(negedge mclk);
        @(negedge mclk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got %0d entries expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/programmable_clock_divider.md
PROGRAMMABLE_CLOCK_DIVIDER -- requirements
Module: programmable_clock_divider

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8: width of the divisor and phase counter.
REQ-002 SHALL have parameter RESET_DIV, default 0: divisor loaded at reset (0 gives a divide-by-2 output, 20 MHz from 40 MHz).
REQ-003 SHALL have port MCLK_IN  input  1  master clock; all logic on its rising edge.
REQ-004 SHALL have port RST_N_IN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port RUN_IN  input  1  level; 1 = output clock runs, 0 = stop at the end of the current period.
REQ-006 SHALL have port DIV_IN  input  CNT_WIDTH  requested divisor D; half-period = D+1 MCLK cycles.
REQ-007 SHALL have port DIV_LOAD_IN  input  1  single-cycle strobe; captures DIV_IN.
REQ-008 SHALL have port CPUCLK_OUT  output  1  divided clock, registered, glitch-free.
REQ-009 SHALL have port RISE_OUT  output  1  registered pulse, high for the one MCLK cycle in which CPUCLK_OUT is newly 1.
REQ-010 SHALL have port FALL_OUT  output  1  registered pulse, high for the one MCLK cycle in which CPUCLK_OUT is newly 0.
REQ-011 SHALL have port DIV_CUR_OUT  output  CNT_WIDTH  divisor currently in effect.
REQ-012 SHALL have port PEND_OUT  output  1  a loaded divisor is waiting for the next period boundary.

Function
REQ-013 SHALL implement states STOPPED, HIGH and LOW, plus phase counter COUNT (CNT_WIDTH bits), DIV_CUR, DIV_PEND and PEND.
REQ-014 In STOPPED: CPUCLK_OUT=0; with RUN_IN=1, the next edge enters HIGH (CPUCLK_OUT=1, RISE_OUT=1, COUNT=0).
REQ-015 In HIGH or LOW: if COUNT==DIV_CUR, the edge toggles CPUCLK_OUT and clears COUNT; otherwise COUNT increments by 1.
REQ-016 Output period SHALL be exactly 2*(DIV_CUR+1) MCLK cycles at 50% duty; D=2^CNT_WIDTH-1 SHALL work with no counter overflow (equality compare only).
REQ-017 HIGH->LOW SHALL occur unconditionally at the end of a high phase, so a high phase is never truncated.
REQ-018 At the period boundary (end of LOW), the block SHALL enter STOPPED when RUN_IN=0 (CPUCLK_OUT held 0, no RISE_OUT); otherwise it SHALL enter HIGH.
REQ-019 While running, DIV_LOAD_IN SHALL set DIV_PEND<=DIV_IN and PEND<=1; a repeat load SHALL overwrite DIV_PEND (last load wins).
REQ-020 At each period boundary with PEND=1, the block SHALL set DIV_CUR<=DIV_PEND and PEND<=0; the new divisor governs the following high phase.
REQ-021 DIV_LOAD_IN coincident with a period boundary SHALL apply DIV_IN directly to DIV_CUR and leave PEND=0.
REQ-022 DIV_LOAD_IN in STOPPED SHALL set DIV_CUR<=DIV_IN immediately and leave PEND=0.
REQ-023 DIV_LOAD_IN coincident with the STOPPED->HIGH start SHALL apply DIV_IN to the starting period.
REQ-024 DIV_CUR_OUT and PEND_OUT SHALL be the DIV_CUR and PEND registers directly.
REQ-025 RISE_OUT and FALL_OUT SHALL never both be 1, and each SHALL be 0 in STOPPED.
REQ-026 RUN_IN deasserted and reasserted within one period SHALL have no effect; only the RUN_IN value sampled at the boundary matters.

Reset
REQ-027 RST_N_IN=0 SHALL immediately (asynchronously) force STOPPED, CPUCLK_OUT=0, RISE_OUT=0, FALL_OUT=0, COUNT=0, DIV_CUR=RESET_DIV, DIV_PEND=0, PEND=0.
REQ-028 Reset asserted mid-phase SHALL truncate that phase without glitching: CPUCLK_OUT goes only to 0.
REQ-029 After deassertion with RUN_IN=1, the first RISE_OUT SHALL occur on the first MCLK edge.

Verification
REQ-030 Defaults, RUN_IN=1 after reset -> CPUCLK_OUT toggles every MCLK edge (period 2 cycles); RISE_OUT and FALL_OUT alternate every cycle.
REQ-031 Load D=19 while stopped, then RUN_IN=1 -> 20 cycles high, 20 low, period 40 (1 MHz at 40 MHz); DIV_CUR_OUT=19.
REQ-032 Running D=3, load D=1 mid-high-phase -> PEND_OUT=1 until the boundary; current period stays 4+4 cycles, then 2+2; PEND_OUT=0 after the boundary.
REQ-033 Running D=2, RUN_IN=0 one cycle after a rise -> high phase completes 3 cycles, low phase 3 cycles, then CPUCLK_OUT stays 0 with no further pulses; RUN_IN=1 -> rise on the next edge.
REQ-034 CNT_WIDTH=4, D=15 -> 16-cycle half periods with no wrap.
REQ-035 Async reset pulse mid-high with D=5 -> CPUCLK_OUT=0 before the next MCLK edge, and DIV_CUR_OUT=RESET_DIV.
